mdu: RTL and testbench

- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Operands come from the register-file read ports via forwarding muxes.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- HI/LO feed the E-stage result mux for MFHI/MFLO, which then travel down to register-file writeback.
- The hazard unit stalls D on busy and on start.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 43 ++++
 rtl/mdu.sv | 108 ++++++++++
 tb/tb_mdu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit; also used by the hazard unit
// to decode mult-class and MFHI/MFLO stalls.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply and signed/unsigned divide of the latched
// operands; results are only committed by the control FSM in mdu.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] prod;

  // Signed division runs on magnitudes, so 0x80000000 / -1 wraps to
  // 0x80000000 instead of overflowing a signed divider.
  always_comb begin
    sgn         = (op == MULT) || (op == DIV);
    a_neg       = sgn & a[31];
    b_neg       = sgn & b[31];
    prod        = {{32{a_neg}}, a} * {{32{b_neg}}, b};
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    div_by_zero = (b == '0);
    q_mag       = div_by_zero ? '0 : a_mag / b_mag;
    r_mag       = div_by_zero ? '0 : a_mag % b_mag;
    if (is_mul(op)) begin
      {hi_res, lo_res} = prod;
    end else begin
      lo_res = (a_neg ^ b_neg) ? -q_mag : q_mag;
      hi_res = a_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: two-state control FSM with a down-counter that
// delays the HI/LO commit by MULT_CYCLES or DIV_CYCLES.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_res, lo_res;
  logic        div_by_zero;

  mdu_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul(op) || is_div(op)) begin
            op_d    = op;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_mul(op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d = RUN;
          end else if (op == MTHI) begin
            hi_d = A;
          end else if (op == MTLO) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        // start is deliberately not examined here: a second launch while busy
        // is dropped.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!(is_div(op_q) && div_by_zero)) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, arithmetic, divide-by-zero,
// overflow case, start-while-busy and asynchronous reset mid-operation.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = MDU_NOP;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int passed = 0;
  int total  = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one start pulse across a single rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    op    = MDU_NOP;
  endtask

  // Counts sampled cycles with busy high, bounded so a stuck busy still ends.
  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // MULT -1 * 2
    issue(MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_busy_rise", {31'd0, busy}, 32'd1);
    check("mult_lo_before", LO, 32'h0);
    busy_len("mult_busy_len", 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF * 2
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    busy_len("multu_busy_len", 5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // DIV -7 / 2
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len("div_busy_len", 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // DIVU 7 / 2
    issue(DIVU, 32'd7, 32'd2);
    busy_len("divu_busy_len", 10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    // MTHI / MTLO are immediate and touch only one register
    issue(MTHI, 32'h1234, 32'hDEAD);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", HI, 32'h1234);
    check("mthi_lo_kept", LO, 32'd3);
    issue(MTLO, 32'h5678, 32'hBEEF);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_lo", LO, 32'h5678);
    check("mtlo_hi_kept", HI, 32'h1234);

    // Divide by zero keeps HI/LO
    issue(DIVU, 32'd9, 32'd0);
    busy_len("divz_busy_len", 10);
    check("divz_hi", HI, 32'h1234);
    check("divz_lo", LO, 32'h5678);

    // Signed overflow case
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("divov_busy_len", 10);
    check("divov_lo", LO, 32'h8000_0000);
    check("divov_hi", HI, 32'h0);

    // NOP and undefined op codes do nothing
    issue(MDU_NOP, 32'hAAAA_AAAA, 32'd1);
    issue(3'd7, 32'hBBBB_BBBB, 32'd1);
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", HI, 32'h0);
    check("undef_lo", LO, 32'h8000_0000);

    // Start while busy is ignored; operand changes during RUN are ignored
    issue(MULT, 32'd3, 32'd4);
    issue(DIVU, 32'd100, 32'd7);
    A = 32'hFFFF_0000;
    B = 32'h0000_FFFF;
    busy_len("sbusy_remaining", 4);
    check("sbusy_hi", HI, 32'h0);
    check("sbusy_lo", LO, 32'd12);
    step();
    step();
    check("sbusy_idle_after", {31'd0, busy}, 32'd0);
    check("sbusy_lo_after", LO, 32'd12);

    // Asynchronous reset in cycle 4 of a DIV discards it
    issue(DIV, 32'd100, 32'd7);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", HI, 32'h0);
    check("rst_mid_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("rst_post_busy", {31'd0, busy}, 32'd0);
    check("rst_post_hi", HI, 32'h0);
    check("rst_post_lo", LO, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
